// File: rtl/mmio_router.sv
// Address-window router from the CPU memory port to NUM_TARGETS memory-mapped targets.
// Tracks one outstanding read and answers unmapped or hung accesses with an error response.
module mmio_router #(
    parameter int unsigned                 NUM_TARGETS    = 4,
    parameter logic [32*NUM_TARGETS-1:0]   REGION_BASE    = {NUM_TARGETS{32'h0}},
    parameter logic [32*NUM_TARGETS-1:0]   REGION_LIMIT   = {NUM_TARGETS{32'hFFFF_FFFF}},
    parameter int unsigned                 DEFAULT_TARGET = NUM_TARGETS - 1,
    parameter int unsigned                 TIMEOUT_CYCLES = 1024,
    parameter logic [31:0]                 ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         input_cmd_start,
    input  logic                         input_cmd_write,
    output logic                         output_cmd_ready,
    input  logic [31:0]                  input_addr,
    input  logic [31:0]                  input_wdata,
    output logic [31:0]                  output_rdata,
    output logic                         output_rdata_valid,
    output logic                         output_err,
    output logic [NUM_TARGETS-1:0]       tgt_cmd_start,
    output logic [NUM_TARGETS-1:0]       tgt_cmd_write,
    input  logic [NUM_TARGETS-1:0]       tgt_cmd_ready,
    output logic [32*NUM_TARGETS-1:0]    tgt_addr,
    output logic [31:0]                  tgt_wdata,
    input  logic [32*NUM_TARGETS-1:0]    tgt_rdata,
    input  logic [NUM_TARGETS-1:0]       tgt_rdata_valid
);

    localparam int unsigned SW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic        DEF_MAPPED = (DEFAULT_TARGET < NUM_TARGETS);
    localparam logic [SW-1:0] DEF_SEL  = DEF_MAPPED ? SW'(DEFAULT_TARGET) : '0;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_READ,
        ERR_RESP
    } state_t;

    state_t        state;
    logic [SW-1:0] cur;
    logic [CW-1:0] cnt;
    logic          err_read;

    logic [SW-1:0] sel;
    logic          mapped;
    logic          found;
    logic          accept;

    // Lowest-index window wins: later matches are skipped once one is found.
    always_comb begin
        sel    = DEF_SEL;
        mapped = DEF_MAPPED;
        found  = 1'b0;
        for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
            if (!found &&
                input_addr >= REGION_BASE[32*i +: 32] &&
                input_addr <= REGION_LIMIT[32*i +: 32]) begin
                found  = 1'b1;
                sel    = SW'(i);
                mapped = 1'b1;
            end
        end
    end

    always_comb begin
        tgt_addr = '0;
        for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
            tgt_addr[32*i +: 32] = input_addr - REGION_BASE[32*i +: 32];
        end
    end

    assign tgt_wdata = input_wdata;
    assign accept    = input_cmd_start && output_cmd_ready;

    always_comb begin
        output_cmd_ready   = 1'b0;
        tgt_cmd_start      = '0;
        tgt_cmd_write      = '0;
        output_rdata       = '0;
        output_rdata_valid = 1'b0;
        output_err         = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n) begin
                    output_cmd_ready = mapped ? tgt_cmd_ready[sel] : 1'b1;
                    if (mapped) begin
                        tgt_cmd_start[sel] = input_cmd_start;
                        tgt_cmd_write[sel] = input_cmd_write;
                    end
                end
            end
            WAIT_READ: begin
                output_rdata       = tgt_rdata[32*cur +: 32];
                output_rdata_valid = tgt_rdata_valid[cur];
            end
            ERR_RESP: begin
                output_err = 1'b1;
                if (err_read) begin
                    output_rdata       = ERR_RDATA;
                    output_rdata_valid = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur      <= '0;
            cnt      <= '0;
            err_read <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!mapped) begin
                            state    <= ERR_RESP;
                            err_read <= !input_cmd_write;
                        end else if (!input_cmd_write) begin
                            state <= WAIT_READ;
                            cur   <= sel;
                            cnt   <= '0;
                        end
                    end
                end
                WAIT_READ: begin
                    // Data arriving on the final timeout cycle takes priority over the error.
                    if (tgt_rdata_valid[cur]) begin
                        state <= IDLE;
                    end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_LAST) begin
                        state    <= ERR_RESP;
                        err_read <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ERR_RESP: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_router.sv
// Directed and randomized checks of mmio_router against a window-table reference model.
module tb_mmio_router;

    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         input_cmd_start;
    logic         input_cmd_write;
    logic         output_cmd_ready;
    logic [31:0]  input_addr;
    logic [31:0]  input_wdata;
    logic [31:0]  output_rdata;
    logic         output_rdata_valid;
    logic         output_err;
    logic [3:0]   tgt_cmd_start;
    logic [3:0]   tgt_cmd_write;
    logic [3:0]   tgt_cmd_ready;
    logic [127:0] tgt_addr;
    logic [31:0]  tgt_wdata;
    logic [127:0] tgt_rdata;
    logic [3:0]   tgt_rdata_valid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] base [4];
    logic [31:0] lim  [4];
    logic [31:0] unm  [6];

    mmio_router #(
        .NUM_TARGETS    (4),
        .REGION_BASE    ({32'hFFFF_FF00, 32'hFF00_0010, 32'hFF00_0000, 32'h0000_0000}),
        .REGION_LIMIT   ({32'hFFFF_FF1F, 32'hFF00_001F, 32'hFF00_000F, 32'h0000_0FFF}),
        .DEFAULT_TARGET (4),
        .TIMEOUT_CYCLES (8),
        .ERR_RDATA      (ERRD)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .input_cmd_start    (input_cmd_start),
        .input_cmd_write    (input_cmd_write),
        .output_cmd_ready   (output_cmd_ready),
        .input_addr         (input_addr),
        .input_wdata        (input_wdata),
        .output_rdata       (output_rdata),
        .output_rdata_valid (output_rdata_valid),
        .output_err         (output_err),
        .tgt_cmd_start      (tgt_cmd_start),
        .tgt_cmd_write      (tgt_cmd_write),
        .tgt_cmd_ready      (tgt_cmd_ready),
        .tgt_addr           (tgt_addr),
        .tgt_wdata          (tgt_wdata),
        .tgt_rdata          (tgt_rdata),
        .tgt_rdata_valid    (tgt_rdata_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Reference decode: first window containing the address, or 4 for unmapped.
    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < 4; i++) begin
            if (a >= base[i] && a <= lim[i]) return i;
        end
        return 4;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr, wd, rd, off;
        logic [3:0]  rdy;
        logic        wr, exp_ready;
        int          t, r, lat, spur;

        base[0] = 32'h0000_0000; lim[0] = 32'h0000_0FFF;
        base[1] = 32'hFF00_0000; lim[1] = 32'hFF00_000F;
        base[2] = 32'hFF00_0010; lim[2] = 32'hFF00_001F;
        base[3] = 32'hFFFF_FF00; lim[3] = 32'hFFFF_FF1F;
        unm[0] = 32'h0000_1000; unm[1] = 32'h8000_0000; unm[2] = 32'hFF00_0020;
        unm[3] = 32'hFFFF_FEFF; unm[4] = 32'hFFFF_FF20; unm[5] = 32'hFEFF_FFFF;

        rst_n = 1'b0;
        input_cmd_start = 1'b1; input_cmd_write = 1'b0;
        input_addr = 32'h10; input_wdata = '0;
        tgt_cmd_ready = '1; tgt_rdata = '0; tgt_rdata_valid = 4'b0001;

        // Reset state: outputs forced quiet even with a live request.
        settle();
        chk("rst_ready", 32'(output_cmd_ready), 32'd0);
        chk("rst_start", 32'(tgt_cmd_start), 32'd0);
        chk("rst_valid", 32'(output_rdata_valid), 32'd0);
        chk("rst_err",   32'(output_err), 32'd0);
        chk("rst_rdata", output_rdata, 32'd0);
        tick();
        input_cmd_start = 1'b0; tgt_rdata_valid = '0;
        rst_n = 1'b1;

        // RAM read with two-cycle latency.
        tick();
        input_addr = 32'h0000_0010; input_cmd_write = 1'b0; input_cmd_start = 1'b1;
        settle();
        chk("t1_start", 32'(tgt_cmd_start), 32'b0001);
        chk("t1_addr",  tgt_addr[31:0], 32'h10);
        chk("t1_ready", 32'(output_cmd_ready), 32'd1);
        tick();
        input_cmd_start = 1'b0;
        settle();
        chk("t1_wait_ready", 32'(output_cmd_ready), 32'd0);
        chk("t1_wait_valid", 32'(output_rdata_valid), 32'd0);
        tick();
        tgt_rdata[31:0] = 32'h1234_5678; tgt_rdata_valid[0] = 1'b1;
        settle();
        chk("t1_valid", 32'(output_rdata_valid), 32'd1);
        chk("t1_rdata", output_rdata, 32'h1234_5678);
        tick();
        tgt_rdata_valid[0] = 1'b0;
        settle();
        chk("t1_after_valid", 32'(output_rdata_valid), 32'd0);
        chk("t1_after_ready", 32'(output_cmd_ready), 32'd1);

        // Back-to-back UART TX writes.
        tick();
        input_addr = 32'hFF00_0004; input_cmd_write = 1'b1; input_wdata = 32'h41; input_cmd_start = 1'b1;
        settle();
        chk("t2_start", 32'(tgt_cmd_start), 32'b0010);
        chk("t2_write", 32'(tgt_cmd_write), 32'b0010);
        chk("t2_addr",  tgt_addr[63:32], 32'h4);
        chk("t2_wdata", tgt_wdata, 32'h41);
        chk("t2_valid", 32'(output_rdata_valid), 32'd0);
        tick();
        input_addr = 32'hFF00_0008; input_wdata = 32'h42;
        settle();
        chk("t2b_ready", 32'(output_cmd_ready), 32'd1);
        chk("t2b_start", 32'(tgt_cmd_start), 32'b0010);
        chk("t2b_addr",  tgt_addr[63:32], 32'h8);
        tick();
        input_cmd_start = 1'b0;
        settle();
        chk("t2_no_valid", 32'(output_rdata_valid), 32'd0);
        chk("t2_no_err",   32'(output_err), 32'd0);

        // Unmapped read.
        tick();
        input_addr = 32'h8000_0000; input_cmd_write = 1'b0; input_cmd_start = 1'b1;
        settle();
        chk("t3_start", 32'(tgt_cmd_start), 32'd0);
        chk("t3_ready", 32'(output_cmd_ready), 32'd1);
        tick();
        input_cmd_start = 1'b0;
        settle();
        chk("t3_err",   32'(output_err), 32'd1);
        chk("t3_valid", 32'(output_rdata_valid), 32'd1);
        chk("t3_rdata", output_rdata, ERRD);
        chk("t3_ready_busy", 32'(output_cmd_ready), 32'd0);
        tick();
        settle();
        chk("t3_err_done", 32'(output_err), 32'd0);
        chk("t3_ready_back", 32'(output_cmd_ready), 32'd1);

        // MTIME read that never answers: error after eight waiting cycles.
        tick();
        input_addr = 32'hFFFF_FF04; input_cmd_start = 1'b1;
        settle();
        chk("t4_start", 32'(tgt_cmd_start), 32'b1000);
        chk("t4_addr",  tgt_addr[127:96], 32'h4);
        tick();
        input_cmd_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            settle();
            chk($sformatf("t4_wait%0d_err", k), 32'(output_err), 32'd0);
            chk($sformatf("t4_wait%0d_ready", k), 32'(output_cmd_ready), 32'd0);
            tick();
        end
        settle();
        chk("t4_err",   32'(output_err), 32'd1);
        chk("t4_valid", 32'(output_rdata_valid), 32'd1);
        chk("t4_rdata", output_rdata, ERRD);
        tick();
        settle();
        chk("t4_ready_back", 32'(output_cmd_ready), 32'd1);
        chk("t4_err_done", 32'(output_err), 32'd0);

        // MTIME answers on the last waiting cycle: data beats the timeout.
        tick();
        input_cmd_start = 1'b1;
        tick();
        input_cmd_start = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        tgt_rdata[127:96] = 32'hCAFE_0003; tgt_rdata_valid[3] = 1'b1;
        settle();
        chk("t4b_valid", 32'(output_rdata_valid), 32'd1);
        chk("t4b_rdata", output_rdata, 32'hCAFE_0003);
        chk("t4b_err",   32'(output_err), 32'd0);
        tick();
        tgt_rdata_valid[3] = 1'b0;
        settle();
        chk("t4b_no_err", 32'(output_err), 32'd0);
        chk("t4b_ready",  32'(output_cmd_ready), 32'd1);

        // Valid in the acceptance cycle and a spurious valid from another target.
        tick();
        input_addr = 32'h0000_0020; input_cmd_start = 1'b1;
        tgt_rdata[31:0] = 32'h0BAD_0000; tgt_rdata_valid[0] = 1'b1;
        settle();
        chk("t5_accept_valid", 32'(output_rdata_valid), 32'd0);
        tick();
        input_cmd_start = 1'b0; tgt_rdata_valid[0] = 1'b0;
        tgt_rdata[63:32] = 32'h0BAD_0001; tgt_rdata_valid[1] = 1'b1;
        settle();
        chk("t5_spurious", 32'(output_rdata_valid), 32'd0);
        tick();
        tgt_rdata_valid[1] = 1'b0;
        tgt_rdata[31:0] = 32'hAAAA_5555; tgt_rdata_valid[0] = 1'b1;
        settle();
        chk("t5_valid", 32'(output_rdata_valid), 32'd1);
        chk("t5_rdata", output_rdata, 32'hAAAA_5555);
        tick();
        tgt_rdata_valid[0] = 1'b0;

        // Reset during a pending read; a late RAM valid must be ignored.
        tick();
        input_addr = 32'h0000_0040; input_cmd_start = 1'b1;
        tick();
        input_cmd_start = 1'b0;
        settle();
        chk("t6_wait_ready", 32'(output_cmd_ready), 32'd0);
        tick();
        rst_n = 1'b0;
        settle();
        chk("t6_rst_ready", 32'(output_cmd_ready), 32'd0);
        chk("t6_rst_valid", 32'(output_rdata_valid), 32'd0);
        chk("t6_rst_err",   32'(output_err), 32'd0);
        tick();
        rst_n = 1'b1;
        tgt_rdata[31:0] = 32'h5757_5757; tgt_rdata_valid[0] = 1'b1;
        settle();
        chk("t6_stale_valid", 32'(output_rdata_valid), 32'd0);
        chk("t6_idle_ready",  32'(output_cmd_ready), 32'd1);
        tick();
        tgt_rdata_valid[0] = 1'b0;

        // Randomized transactions checked against the window-table model.
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 4);
            if (r < 4) begin
                case ($urandom_range(0, 2))
                    0:       off = 32'd0;
                    1:       off = lim[r] - base[r];
                    default: off = $urandom_range(0, lim[r] - base[r]);
                endcase
                addr = base[r] + off;
            end else begin
                addr = unm[$urandom_range(0, 5)];
            end
            wr  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            rdy = 4'($urandom);
            t   = ref_decode(addr);
            exp_ready = (t == 4) ? 1'b1 : rdy[t];

            tick();
            input_addr = addr; input_cmd_write = wr; input_wdata = wd;
            input_cmd_start = 1'b1; tgt_cmd_ready = rdy;
            settle();
            chk($sformatf("r%0d_ready", it), 32'(output_cmd_ready), 32'(exp_ready));
            chk($sformatf("r%0d_start", it), 32'(tgt_cmd_start), (t == 4) ? 32'd0 : (32'd1 << t));
            chk($sformatf("r%0d_wdata", it), tgt_wdata, wd);
            if (t != 4) chk($sformatf("r%0d_addr", it), tgt_addr[32*t +: 32], addr - base[t]);
            if (!exp_ready) begin
                tick();
                tgt_cmd_ready[t] = 1'b1;
                settle();
                chk($sformatf("r%0d_ready_late", it), 32'(output_cmd_ready), 32'd1);
            end
            tick();
            input_cmd_start = 1'b0;
            if (t == 4) begin
                settle();
                chk($sformatf("r%0d_uerr", it), 32'(output_err), 32'd1);
                chk($sformatf("r%0d_uvalid", it), 32'(output_rdata_valid), 32'(!wr));
                chk($sformatf("r%0d_urdata", it), output_rdata, wr ? 32'd0 : ERRD);
            end else if (wr) begin
                settle();
                chk($sformatf("r%0d_wvalid", it), 32'(output_rdata_valid), 32'd0);
                chk($sformatf("r%0d_werr", it), 32'(output_err), 32'd0);
            end else begin
                lat  = $urandom_range(1, 4);
                spur = $urandom_range(0, 3);
                rd   = $urandom;
                for (int c = 1; c < lat; c++) begin
                    if (c == 1 && spur != t) begin
                        tgt_rdata[32*spur +: 32] = $urandom;
                        tgt_rdata_valid[spur] = 1'b1;
                    end
                    settle();
                    chk($sformatf("r%0d_c%0d_valid", it, c), 32'(output_rdata_valid), 32'd0);
                    chk($sformatf("r%0d_c%0d_ready", it, c), 32'(output_cmd_ready), 32'd0);
                    tick();
                    tgt_rdata_valid = '0;
                end
                tgt_rdata[32*t +: 32] = rd; tgt_rdata_valid[t] = 1'b1;
                settle();
                chk($sformatf("r%0d_rvalid", it), 32'(output_rdata_valid), 32'd1);
                chk($sformatf("r%0d_rdata", it), output_rdata, rd);
                chk($sformatf("r%0d_rerr", it), 32'(output_err), 32'd0);
                tick();
                tgt_rdata_valid = '0;
            end
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
